ssm3_msg_sched: RTL and testbench
=================================

// Module: ssm3_msg_sched
// PURPOSE
//  Sequencer for the SM3 message-expansion datapath (P1 permutation) used by the
//  SM3 hash accelerator. Accepts one 512-bit block as 16 32-bit words, then streams
//  (W_j, W'_j) pairs for j = 0..NROUNDS-1 to the compression round engine.
//  A 16-word sliding window holds the expansion state; one new word is computed per
//  accepted output beat with the P1/P0-style rotate-XOR logic, so no round storage is needed.
// PARAMETERS
//  NROUNDS  64  number of (W_j, W'_j) pairs emitted per block; legal range 1..64
// PORTS
//  g_clk      in   1   clock; all state updates on the rising edge
//  g_resetn   in   1   asynchronous active-low reset
//  flush      in   1   synchronous abort: discard the block in progress, return to IDLE
//  in_valid   in   1   message word valid
//  in_ready   out  1   scheduler can accept a message word
//  in_word    in   32  message word, big-endian word order W_0 first
//  out_valid  out  1   (W_j, W'_j) pair valid
//  out_ready  in   1   round engine accepts the pair
//  out_w      out  32  W_j
//  out_wp     out  32  W'_j = W_j ^ W_{j+4}
//  out_idx    out  6   round index j
//  out_last   out  1   high with out_valid when j == NROUNDS-1
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  - Reset (async, g_resetn=0): state=IDLE, load count=0, j=0, window=all zero;
//    in_ready=1, out_valid=0, out_last=0, busy=0, out_w=out_wp=0, out_idx=0.
//  - States: IDLE -> LOAD -> RUN -> IDLE.
//    IDLE: in_ready=1. Accepted word (in_valid&&in_ready) -> win[0], count=1, go LOAD.
//    LOAD: in_ready=1. Each accepted word written to win[count], count++.
//          Accepting word 15 -> RUN, j=0. No output beats during LOAD.
//    RUN:  in_ready=0, out_valid=1. On out_valid&&out_ready: shift window down one
//          (win[i]<=win[i+1]), win[15]<=E, j++. If j==NROUNDS-1 on that beat -> IDLE,
//          j=0, count=0, window left as-is.
//  - Expansion word E (combinational from window, i.e. W_{j+16}):
//      x = win[0] ^ win[7] ^ ROL32(win[13],15)
//      E = (x ^ ROL32(x,15) ^ ROL32(x,23)) ^ ROL32(win[3],7) ^ win[10]
//    All arithmetic is 32-bit XOR/rotate, no carries.
//  - Outputs are combinational from registered state: out_w=win[0],
//    out_wp=win[0]^win[4], out_idx=j, out_last=(j==NROUNDS-1). out_w/out_wp/out_idx
//    are don't-care when out_valid=0 but must not be X.
//  - Latency: word 15 accepted in cycle N -> out_valid=1 in cycle N+1 with j=0.
//    Throughput 1 pair/cycle with out_ready held high; block of 16 words + 64 pairs
//    = 80 cycles minimum, back-to-back blocks: word 0 of next block accepted the cycle
//    after the out_last beat.
//  - Backpressure: with out_valid=1 and out_ready=0, window, j and outputs hold stable.
//  - in_valid gaps during LOAD are allowed; count holds.
//  - flush: highest priority over any handshake in the same cycle; next cycle
//    state=IDLE, count=0, j=0, out_valid=0; a word presented in the flush cycle is
//    dropped. flush in IDLE is a no-op.
//  - Async reset asserted mid-LOAD or mid-RUN: immediately returns to reset values;
//    the partial block is lost, no output beat is produced.
// TESTING
//  1. "abc" block: W0=0x61626380, W1..W14=0, W15=0x00000018, out_ready=1 ->
//     j=0 out_w=0x61626380 out_wp=0x61626380; j=16 out_w=0x9092E200;
//     j=17 out_w=0x00000000; j=18 out_w=0x000C0606; j=19 out_w=0x719C70ED;
//     out_last only at j=63; busy falls the cycle after.
//  2. Random out_ready (50%) on block of test 1 -> identical 64-pair sequence as
//     test 1, outputs stable on every stalled cycle, exactly 64 handshakes.
//  3. in_valid with gaps during LOAD, two blocks back-to-back -> second block's
//     word 0 accepted the cycle after out_last beat; both sequences match model.
//  4. flush asserted at j=10 with out_ready=1 -> no beat counted for that cycle,
//     next cycle IDLE, in_ready=1; next block restarts at j=0 with correct data.
//  5. g_resetn pulsed low during LOAD after 7 words -> all outputs at reset values
//     asynchronously; subsequent full block produces correct j=0..63 sequence.
//  6. NROUNDS=4 build -> exactly 4 pairs per block, out_last at j=3, then IDLE.

Source files
------------

// File: rtl/ssm3_msg_sched.sv
// ssm3_msg_sched
// Message-expansion sequencer for the SM3 hash core. It loads one 512-bit
// block as sixteen 32-bit words, then streams (W_j, W'_j) pairs to the
// compression round engine. A 16-word sliding window carries the expansion
// state, and one new word W_{j+16} is produced for each accepted output beat.
module ssm3_msg_sched #(
  parameter int NROUNDS = 64
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_w,
  output logic [31:0] out_wp,
  output logic [5:0]  out_idx,
  output logic        out_last,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  // Index of the final pair of a block.
  localparam logic [5:0] LAST_IDX = 6'(NROUNDS - 1);

  state_t      r_state;
  logic [3:0]  r_count;
  logic [5:0]  r_j;
  logic [31:0] r_win [16];

  logic        w_inFire;
  logic        w_outFire;
  logic        w_isLast;
  logic [31:0] w_rot13;
  logic [31:0] w_x;
  logic [31:0] w_p1;
  logic [31:0] w_rot3;
  logic [31:0] w_exp;

  // The window always holds W_j .. W_{j+15}, so the word that slides in next
  // is W_{j+16}:
  //   x = W_j ^ W_{j+7} ^ ROL(W_{j+13},15)
  //   E = P1(x) ^ ROL(W_{j+3},7) ^ W_{j+10}
  // All rotates are fixed, so they are plain bit rewiring.
  assign w_rot13 = {r_win[13][16:0], r_win[13][31:17]};
  assign w_x     = r_win[0] ^ r_win[7] ^ w_rot13;
  assign w_p1    = w_x ^ {w_x[16:0], w_x[31:17]} ^ {w_x[8:0], w_x[31:9]};
  assign w_rot3  = {r_win[3][24:0], r_win[3][31:25]};
  assign w_exp   = w_p1 ^ w_rot3 ^ r_win[10];

  // Handshake decode. Words are accepted in IDLE and LOAD, and pairs are
  // offered only in RUN, so the two interfaces never fire together.
  assign in_ready  = (r_state != S_RUN);
  assign out_valid = (r_state == S_RUN);
  assign w_inFire  = in_valid && in_ready;
  assign w_outFire = out_valid && out_ready;
  assign w_isLast  = (r_j == LAST_IDX);

  // The outputs are read straight off the window head. The window is cleared
  // on reset, so these outputs are never X even when out_valid is low.
  assign out_w    = r_win[0];
  assign out_wp   = r_win[0] ^ r_win[4];
  assign out_idx  = r_j;
  assign out_last = out_valid && w_isLast;
  assign busy     = (r_state != S_IDLE);

  // Sequencer state machine and window update. Flush takes priority over both
  // handshakes: a word offered in the flush cycle is dropped, and a pair
  // offered in that cycle is not counted. The window keeps its contents after
  // a flush or after the last beat. The next block overwrites every slot
  // before any pair is emitted, so stale words are never seen.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state <= S_IDLE;
      r_count <= 4'd0;
      r_j     <= 6'd0;
      for (int i = 0; i < 16; i++) begin
        r_win[i] <= 32'd0;
      end
    end else if (flush) begin
      r_state <= S_IDLE;
      r_count <= 4'd0;
      r_j     <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_inFire) begin
            r_win[0] <= in_word;
            r_count  <= 4'd1;
            r_state  <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (w_inFire) begin
            r_win[r_count] <= in_word;
            r_count        <= r_count + 4'd1;
            if (r_count == 4'd15) begin
              r_state <= S_RUN;
              r_j     <= 6'd0;
            end
          end
        end

        S_RUN: begin
          if (w_outFire) begin
            for (int i = 0; i < 15; i++) begin
              r_win[i] <= r_win[i + 1];
            end
            r_win[15] <= w_exp;
            if (w_isLast) begin
              r_state <= S_IDLE;
              r_j     <= 6'd0;
              r_count <= 4'd0;
            end else begin
              r_j <= r_j + 6'd1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_count <= 4'd0;
          r_j     <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ssm3_msg_sched.sv
// tb_ssm3_msg_sched
// Self-checking bench for the SM3 message scheduler. A reference model in the
// bench expands every accepted block straight from the SM3 recurrence and
// queues the pairs it expects. One monitor compares the DUT against that queue
// on every falling clock edge. A second instance built with NROUNDS=4 checks
// the short-block configuration.
module tb_ssm3_msg_sched;

  typedef logic [15:0][31:0] blk_t;
  typedef logic [67:0][31:0] wexp_t;
  typedef struct {
    logic [31:0] w;
    logic [31:0] wp;
    int          idx;
    logic        last;
  } beat_t;

  logic        clk;
  logic        g_resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_w;
  logic [31:0] out_wp;
  logic [5:0]  out_idx;
  logic        out_last;
  logic        busy;

  logic        flush4;
  logic        in_valid4;
  logic        in_ready4;
  logic [31:0] in_word4;
  logic        out_valid4;
  logic        out_ready4;
  logic [31:0] out_w4;
  logic [31:0] out_wp4;
  logic [5:0]  out_idx4;
  logic        out_last4;
  logic        busy4;

  int total = 0;
  int bad   = 0;

  // Reference model state, updated only by the monitor.
  beat_t       expQ[$];
  blk_t        accBlk;
  int          loadCnt = 0;
  int          cyc = 0;
  int          beats = 0;
  int          lastBeatCyc = -100;
  int          lastGap = 0;
  int          lastCount = 0;
  int          lastIdxSeen = -1;
  logic [31:0] obsW  [64];
  logic [31:0] obsWp [64];

  blk_t        blk;
  logic        readyRandom = 1'b0;

  ssm3_msg_sched #(.NROUNDS(64)) dut (
    .g_clk     (clk),
    .g_resetn  (g_resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_w     (out_w),
    .out_wp    (out_wp),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  ssm3_msg_sched #(.NROUNDS(4)) dut4 (
    .g_clk     (clk),
    .g_resetn  (g_resetn),
    .flush     (flush4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .in_word   (in_word4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_w     (out_w4),
    .out_wp    (out_wp4),
    .out_idx   (out_idx4),
    .out_last  (out_last4),
    .busy      (busy4)
  );

  // 100 MHz free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Full SM3 message expansion W_0..W_67, computed from the standard recurrence.
  function automatic wexp_t expand(input blk_t m);
    wexp_t       w;
    logic [31:0] x;
    for (int j = 0; j < 16; j++) w[j] = m[j];
    for (int j = 16; j < 68; j++) begin
      x    = w[j-16] ^ w[j-9] ^ rol(w[j-3], 15);
      w[j] = x ^ rol(x, 15) ^ rol(x, 23) ^ rol(w[j-13], 7) ^ w[j-6];
    end
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Presents the first nWords words of blk, inserting random in_valid gaps.
  // A word advances only once it has been taken, so this also waits while a
  // previous block is still streaming out.
  task automatic applyStimulus(input int gapPct, input int nWords);
    int  i = 0;
    int  guard = 0;
    logic acc;
    while (i < nWords && guard < 2000) begin
      if ($urandom_range(99) < gapPct) begin
        in_valid = 1'b0;
        in_word  = $urandom;
      end else begin
        in_valid = 1'b1;
        in_word  = blk[i];
      end
      @(negedge clk);
      acc = in_valid && in_ready && !flush;
      @(posedge clk);
      #1;
      if (acc) i++;
      guard++;
    end
    in_valid = 1'b0;
    in_word  = $urandom;
    if (guard >= 2000) reportTimeout("load words");
  endtask

  // Waits until the model says the block has fully drained.
  task automatic waitIdle();
    int guard = 0;
    while ((expQ.size() != 0 || loadCnt != 0) && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    #1;
    if (guard >= 5000) reportTimeout("drain block");
  endtask

  task automatic randomBlock();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
  endtask

  // Drives out_ready: held high, or a fair coin each cycle while readyRandom is set.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = readyRandom ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  // Monitor and reference model. On each falling edge it compares every DUT
  // output against the model, then applies the handshake that the next rising
  // edge will commit: flush, an output beat, or an accepted word.
  always @(negedge clk) begin
    beat_t e;
    wexp_t w;
    cyc++;
    if (!g_resetn) begin
      expQ.delete();
      loadCnt = 0;
      checkOutput("reset in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset out_last", 32'(out_last), 32'd0);
      checkOutput("reset out_w", out_w, 32'd0);
      checkOutput("reset out_wp", out_wp, 32'd0);
      checkOutput("reset out_idx", 32'(out_idx), 32'd0);
    end else begin
      checkOutput("in_ready", 32'(in_ready), 32'(expQ.size() == 0));
      checkOutput("out_valid", 32'(out_valid), 32'(expQ.size() != 0));
      checkOutput("busy", 32'(busy), 32'(expQ.size() != 0 || loadCnt != 0));
      if (expQ.size() != 0) begin
        e = expQ[0];
        checkOutput("out_w", out_w, e.w);
        checkOutput("out_wp", out_wp, e.wp);
        checkOutput("out_idx", 32'(out_idx), 32'(e.idx));
        checkOutput("out_last", 32'(out_last), 32'(e.last));
      end else begin
        checkOutput("out_last idle", 32'(out_last), 32'd0);
      end

      if (flush) begin
        expQ.delete();
        loadCnt = 0;
      end else if (expQ.size() != 0) begin
        if (out_ready) begin
          e = expQ.pop_front();
          beats++;
          obsW[e.idx]  = out_w;
          obsWp[e.idx] = out_wp;
          if (out_last) begin
            lastCount++;
            lastIdxSeen = int'(out_idx);
          end
          if (e.last) lastBeatCyc = cyc;
        end
      end else if (in_valid) begin
        if (loadCnt == 0) lastGap = cyc - lastBeatCyc;
        accBlk[loadCnt] = in_word;
        loadCnt++;
        if (loadCnt == 16) begin
          w = expand(accBlk);
          for (int j = 0; j < 64; j++) begin
            expQ.push_back('{w[j], w[j] ^ w[j+4], j, (j == 63)});
          end
          loadCnt = 0;
        end
      end
    end
  end

  // Overall time bound so the run always ends, even if the DUT hangs.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog");
  end

  // Test sequence.
  initial begin
    wexp_t w;
    wexp_t w4;
    int    b0;
    int    n4;
    bit    done;

    g_resetn  = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_word   = 32'd0;
    flush4    = 1'b0;
    in_valid4 = 1'b0;
    in_word4  = 32'd0;
    out_ready4 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    g_resetn = 1'b1;
    @(posedge clk);
    #1;

    // Pin the model against hand-known SM3 "abc" expansion words.
    blk = '0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    w = expand(blk);
    checkOutput("model W16", w[16], 32'h9092E200);
    checkOutput("model W18", w[18], 32'h000C0606);
    checkOutput("model W19", w[19], 32'h719C70ED);

    // Test 1: "abc" block with out_ready held high.
    $display("[TB] test 1: abc block");
    lastCount = 0;
    applyStimulus(0, 16);
    waitIdle();
    checkOutput("t1 busy after last", 32'(busy), 32'd0);
    checkOutput("t1 W0", obsW[0], 32'h61626380);
    checkOutput("t1 Wp0", obsWp[0], 32'h61626380);
    checkOutput("t1 W16", obsW[16], 32'h9092E200);
    checkOutput("t1 W17", obsW[17], 32'h00000000);
    checkOutput("t1 W18", obsW[18], 32'h000C0606);
    checkOutput("t1 W19", obsW[19], 32'h719C70ED);
    checkOutput("t1 last count", 32'(lastCount), 32'd1);
    checkOutput("t1 last idx", 32'(lastIdxSeen), 32'd63);

    // Test 2: same block with random backpressure.
    $display("[TB] test 2: random out_ready");
    b0 = beats;
    readyRandom = 1'b1;
    applyStimulus(0, 16);
    waitIdle();
    readyRandom = 1'b0;
    checkOutput("t2 handshakes", 32'(beats - b0), 32'd64);
    checkOutput("t2 W19", obsW[19], 32'h719C70ED);

    // Test 3: gapped load, then a second block queued back-to-back.
    $display("[TB] test 3: back-to-back blocks");
    randomBlock();
    applyStimulus(30, 16);
    randomBlock();
    applyStimulus(0, 16);
    checkOutput("t3 b2b gap", 32'(lastGap), 32'd1);
    waitIdle();

    // Test 4: flush mid-RUN at j=10, and flush mid-LOAD with a word presented.
    $display("[TB] test 4: flush");
    randomBlock();
    applyStimulus(0, 16);
    done = 1'b0;
    for (int g = 0; g < 200 && !done; g++) begin
      if (out_valid && out_idx == 6'd10) begin
        flush    = 1'b1;
        in_valid = 1'b1;
        in_word  = $urandom;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        done     = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) reportTimeout("reach j=10");
    checkOutput("t4 in_ready", 32'(in_ready), 32'd1);
    checkOutput("t4 out_valid", 32'(out_valid), 32'd0);
    checkOutput("t4 busy", 32'(busy), 32'd0);
    randomBlock();
    applyStimulus(0, 5);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_word  = $urandom;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("t4 load flush busy", 32'(busy), 32'd0);
    randomBlock();
    applyStimulus(20, 16);
    waitIdle();

    // Test 5: asynchronous reset during LOAD after 7 words.
    $display("[TB] test 5: reset mid-load");
    randomBlock();
    blk[0] = 32'hDEADBEEF;
    applyStimulus(0, 7);
    g_resetn = 1'b0;
    #1;
    checkOutput("t5 async busy", 32'(busy), 32'd0);
    checkOutput("t5 async in_ready", 32'(in_ready), 32'd1);
    checkOutput("t5 async out_valid", 32'(out_valid), 32'd0);
    checkOutput("t5 async out_w", out_w, 32'd0);
    checkOutput("t5 async out_idx", 32'(out_idx), 32'd0);
    @(posedge clk);
    #1;
    g_resetn = 1'b1;
    @(posedge clk);
    #1;
    randomBlock();
    applyStimulus(10, 16);
    waitIdle();

    // Test 6: NROUNDS=4 instance emits exactly four pairs and then idles.
    $display("[TB] test 6: NROUNDS=4");
    randomBlock();
    for (int i = 0; i < 16; i++) begin
      in_valid4 = 1'b1;
      in_word4  = blk[i];
      @(posedge clk);
      #1;
    end
    in_valid4 = 1'b0;
    w4 = expand(blk);
    n4 = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid4) begin
        if (n4 < 4) begin
          checkOutput("r4 out_w", out_w4, w4[n4]);
          checkOutput("r4 out_wp", out_wp4, w4[n4] ^ w4[n4+4]);
          checkOutput("r4 out_idx", 32'(out_idx4), 32'(n4));
          checkOutput("r4 out_last", 32'(out_last4), 32'(n4 == 3));
        end
        n4++;
      end
    end
    checkOutput("r4 beats", 32'(n4), 32'd4);
    checkOutput("r4 busy", 32'(busy4), 32'd0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
